pipe_stage_chain: RTL and testbench

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

---
 rtl/pipe_stage_chain_if.sv | 31 +++
 rtl/pipe_stage_chain.sv | 101 ++++++++++
 tb/tb_pipe_stage_chain.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_if.sv
// Bundle of the pipeline chain's upstream handshake, per-stage controls and observation outputs.
// The master side drives input items and stall/flush; the slave side is the chain itself.
interface pipe_stage_chain_if #(
   parameter int W     = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
);
   logic                   in_valid;
   logic [W-1:0]           in_data;
   logic                   in_ready;
   logic [DEPTH-1:0]       stall;
   logic [DEPTH-1:0]       flush;
   logic [DEPTH-1:0]       stage_valid;
   logic [DEPTH*W-1:0]     stage_data;
   logic                   out_valid;
   logic [W-1:0]           out_data;
   logic [CNT_W-1:0]       retired_count;
   logic [CNT_W-1:0]       flushed_count;

   modport master (
      output in_valid, in_data, stall, flush,
      input  in_ready, stage_valid, stage_data, out_valid, out_data,
             retired_count, flushed_count
   );

   modport slave (
      input  in_valid, in_data, stall, flush,
      output in_ready, stage_valid, stage_data, out_valid, out_data,
             retired_count, flushed_count
   );
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage register chain with per-stage stall/flush; DEPTH cycles latency, 1 item/cycle.
// A stall freezes its stage and everything upstream (in_ready drops); flush overrides stall.
module pipe_stage_chain #(
   parameter int W     = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input logic               clk,
   input logic               rst,
   pipe_stage_chain_if.slave bus
);
   localparam int NW = $clog2(DEPTH + 1);
   localparam int SW = CNT_W + NW + 1;

   logic [DEPTH-1:0]          hold;
   logic [DEPTH-1:0]          cand_vld;
   logic [DEPTH-1:0][W-1:0]   cand_dat;
   logic [DEPTH-1:0]          vld_q, vld_d;
   logic [DEPTH-1:0][W-1:0]   dat_q, dat_d;
   logic [CNT_W-1:0]          ret_cnt_q, ret_cnt_d;
   logic [CNT_W-1:0]          flu_cnt_q, flu_cnt_d;
   logic [NW-1:0]             flu_n;
   logic                      retire;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [NW-1:0]    b);
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      return (s > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   // hold[i] is the OR of stall[j] for every j >= i
   always_comb begin
      hold = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hold[i] = |(bus.stall >> i);
      end
   end

   always_comb begin
      cand_vld = '0;
      cand_dat = '0;
      if (hold[0]) begin
         cand_vld[0] = vld_q[0];
         cand_dat[0] = dat_q[0];
      end else begin
         cand_vld[0] = bus.in_valid;
         cand_dat[0] = bus.in_data;
      end
      // A stage just below a held one takes a bubble (the default zeros).
      for (int i = 1; i < DEPTH; i++) begin
         if (hold[i]) begin
            cand_vld[i] = vld_q[i];
            cand_dat[i] = dat_q[i];
         end else if (!hold[i-1]) begin
            cand_vld[i] = vld_q[i-1];
            cand_dat[i] = dat_q[i-1];
         end
      end
   end

   always_comb begin
      vld_d = '0;
      dat_d = '0;
      flu_n = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.flush[i]) begin
            flu_n = flu_n + NW'(cand_vld[i]);
         end else begin
            vld_d[i] = cand_vld[i];
            dat_d[i] = cand_dat[i];
         end
      end
   end

   assign retire    = vld_q[DEPTH-1] & ~bus.stall[DEPTH-1];
   assign ret_cnt_d = sat_add(ret_cnt_q, NW'(retire));
   assign flu_cnt_d = sat_add(flu_cnt_q, flu_n);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q     <= '0;
         dat_q     <= '0;
         ret_cnt_q <= '0;
         flu_cnt_q <= '0;
      end else begin
         vld_q     <= vld_d;
         dat_q     <= dat_d;
         ret_cnt_q <= ret_cnt_d;
         flu_cnt_q <= flu_cnt_d;
      end
   end

   assign bus.in_ready      = ~hold[0];
   assign bus.stage_valid   = vld_q;
   assign bus.stage_data    = dat_q;
   assign bus.out_valid     = vld_q[DEPTH-1];
   assign bus.out_data      = dat_q[DEPTH-1];
   assign bus.retired_count = ret_cnt_q;
   assign bus.flushed_count = flu_cnt_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (DEPTH=4, W=32, CNT_W=4 so saturation is reachable).
module tb_pipe_stage_chain;
   localparam int W     = 32;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   localparam logic [31:0] A = 32'hAAAA_0001;
   localparam logic [31:0] B = 32'hBBBB_0002;
   localparam logic [31:0] C = 32'hCCCC_0003;
   localparam logic [31:0] D = 32'hDDDD_0004;
   localparam logic [31:0] E = 32'hEEEE_0005;
   localparam logic [31:0] F = 32'hFFFF_0006;
   localparam logic [31:0] G = 32'h1234_0007;
   localparam logic [31:0] H = 32'h5678_0008;

   pipe_stage_chain_if #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   pipe_stage_chain #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] v);
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      step();
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.stall    = '0;
      bus.flush    = '0;
   endtask

   task automatic flush_round();
      for (int k = 0; k < 4; k++) push(32'h0000_0400 + k);
      bus.flush = 4'b1111;
      step();
      bus.flush = 4'b0000;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      #1;
      chk("rst_stage_valid", bus.stage_valid, 0);
      chk("rst_stage_data", bus.stage_data, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_retired", bus.retired_count, 0);
      chk("rst_flushed", bus.flushed_count, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      bus.stall = 4'b1000;
      #1;
      chk("rst_in_ready_stall3", bus.in_ready, 0);
      bus.stall = 4'b0000;
      step();
      chk("rst_out_data", bus.out_data, 0);
      rst = 1'b0;

      // Three-item stream: exits exactly four edges after acceptance
      push(32'h100);
      push(32'h104);
      push(32'h108);
      idle();
      chk("lat_not_early", bus.out_valid, 0);
      step();
      chk("s1_valid", bus.out_valid, 1);
      chk("s1_data", bus.out_data, 32'h100);
      step();
      chk("s2_data", bus.out_data, 32'h104);
      chk("s2_retired", bus.retired_count, 1);
      step();
      chk("s3_data", bus.out_data, 32'h108);
      chk("s3_retired", bus.retired_count, 2);
      step();
      chk("s_retired3", bus.retired_count, 3);
      chk("s_empty", bus.out_valid, 0);

      // stall[2]: stages 0..2 hold, stage 3 gets a bubble, A retires
      push(A); push(B); push(C); push(D);
      bus.in_valid = 1'b1;
      bus.in_data  = E;
      bus.stall    = 4'b0100;
      #1;
      chk("stall2_in_ready", bus.in_ready, 0);
      step();
      chk("stall2_valid", bus.stage_valid, 4'b0111);
      chk("stall2_data", bus.stage_data, {32'h0, B, C, D});
      chk("stall2_retired", bus.retired_count, 4);
      idle();
      #1;
      chk("unstall_in_ready", bus.in_ready, 1);
      repeat (4) step();
      chk("drain_retired", bus.retired_count, 7);
      chk("drain_empty", bus.stage_valid, 0);

      // flush[1:0] with a new item arriving: two valid candidates killed
      push(A); push(B); push(C); push(D);
      bus.in_valid = 1'b1;
      bus.in_data  = E;
      bus.flush    = 4'b0011;
      step();
      chk("flush01_valid", bus.stage_valid, 4'b1100);
      chk("flush01_data", bus.stage_data, {B, C, 32'h0, 32'h0});
      chk("flush01_flushed", bus.flushed_count, 2);
      chk("flush01_retired", bus.retired_count, 8);
      idle();

      // stall[1] + flush[1] on the same edge
      push(F);
      push(G);
      idle();
      chk("pre_sf_valid", bus.stage_valid, 4'b0011);
      bus.in_valid = 1'b1;
      bus.in_data  = H;
      bus.stall    = 4'b0010;
      bus.flush    = 4'b0010;
      #1;
      chk("sf_in_ready", bus.in_ready, 0);
      step();
      chk("sf_valid", bus.stage_valid, 4'b0001);
      chk("sf_data", bus.stage_data, {32'h0, 32'h0, 32'h0, G});
      chk("sf_flushed", bus.flushed_count, 3);
      chk("sf_retired", bus.retired_count, 10);
      idle();

      // Retired counter saturation under a 12-item back-to-back stream
      for (int k = 0; k < 12; k++) push(32'h200 + k);
      idle();
      chk("stream_out_data", bus.out_data, 32'h208);
      chk("stream_retired_sat", bus.retired_count, 15);
      repeat (4) step();
      chk("retired_stays_sat", bus.retired_count, 15);
      chk("stream_drained", bus.out_valid, 0);

      // Flushed counter: multi-increment edges crossing the saturation point
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h300;
      bus.flush    = 4'b0001;
      step();
      chk("flush0_in", bus.flushed_count, 4);
      chk("flush0_bubble", bus.stage_valid, 0);
      bus.flush = 4'b0000;
      flush_round();
      chk("flushall_8", bus.flushed_count, 8);
      chk("flushall_empty", bus.stage_valid, 0);
      flush_round();
      chk("flushall_12", bus.flushed_count, 12);
      flush_round();
      chk("flushed_sat", bus.flushed_count, 15);
      idle();

      // Asynchronous reset between edges with all stages valid
      for (int k = 0; k < 4; k++) push(32'h500 + k);
      idle();
      chk("prerst_full", bus.stage_valid, 4'b1111);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", bus.stage_valid, 0);
      chk("arst_data", bus.stage_data, 0);
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_out_data", bus.out_data, 0);
      chk("arst_retired", bus.retired_count, 0);
      chk("arst_flushed", bus.flushed_count, 0);
      step();
      rst = 1'b0;
      push(32'h600);
      idle();
      repeat (2) step();
      chk("post_rst_not_early", bus.out_valid, 0);
      step();
      chk("post_rst_valid", bus.out_valid, 1);
      chk("post_rst_data", bus.out_data, 32'h600);
      chk("post_rst_counts", {bus.retired_count, bus.flushed_count}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
